// File: rtl/ram_pkg.sv
// Shared constants, FSM state type and test-pattern helper for the 32x8 RAM BIST.
package ram_pkg;

  localparam int unsigned RAM_DEPTH = 32;
  localparam int unsigned RAM_AW    = 5;
  localparam int unsigned RAM_DW    = 8;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    DRAIN,
    DONE
  } bist_state_t;

  // Pass 0 writes the address itself, pass 1 its bitwise inverse; callers keep the low DW bits.
  function automatic logic [31:0] pat(input logic ph, input logic [31:0] a);
    return ph ? ~a : a;
  endfunction

endpackage

// File: rtl/ram_bist_chk.sv
// BIST read checker: one-entry expected/address pipeline, comparator,
// first-fail capture and mismatch counter.
module ram_bist_chk
  import ram_pkg::*;
#(
  parameter int unsigned AW = RAM_AW,
  parameter int unsigned DW = RAM_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          rd,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] rd_exp,
  input  logic [DW-1:0] dout,
  output logic [AW-1:0] fail_addr,
  output logic [DW-1:0] fail_data,
  output logic [AW+1:0] err_count,
  output logic          clean
);

  logic          pv;
  logic [AW-1:0] pa;
  logic [DW-1:0] pe;
  logic          first_seen;
  logic          hit;

  // dout answers the read issued one cycle earlier, so its expectation is delayed to match.
  assign hit   = pv && (dout != pe);
  assign clean = (err_count == '0) && !hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pv <= 1'b0;
      pa <= '0;
      pe <= '0;
    end else begin
      pv <= rd;
      pa <= addr;
      pe <= rd_exp;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count  <= '0;
      fail_addr  <= '0;
      fail_data  <= '0;
      first_seen <= 1'b0;
    end else if (clr) begin
      err_count  <= '0;
      fail_addr  <= '0;
      fail_data  <= '0;
      first_seen <= 1'b0;
    end else if (hit) begin
      err_count <= err_count + (AW+2)'(1);
      if (!first_seen) begin
        first_seen <= 1'b1;
        fail_addr  <= pa;
        fail_data  <= dout;
      end
    end
  end

endmodule

// File: rtl/ram_32x8_bist.sv
// BIST initiator for the 32x8 single-port RAM: writes/reads an address pattern
// and its inverse, reporting pass/fail, first failing location and error count.
module ram_32x8_bist
  import ram_pkg::*;
#(
  parameter int unsigned DEPTH = RAM_DEPTH,
  parameter int unsigned AW    = RAM_AW,
  parameter int unsigned DW    = RAM_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  input  logic [DW-1:0] mem_dout,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW-1:0] fail_addr,
  output logic [DW-1:0] fail_data,
  output logic [AW+1:0] err_count
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  bist_state_t   state, state_n;
  logic          ph, ph_n;
  logic [AW-1:0] cnt, cnt_n;
  logic          clr;
  logic          clean;
  logic          rd_n, wr_n;
  logic [AW-1:0] addr_n;
  logic [DW-1:0] data_n;
  logic [DW-1:0] rd_exp;

  always_comb begin
    state_n = state;
    ph_n    = ph;
    cnt_n   = cnt;
    clr     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          clr     = 1'b1;
          ph_n    = 1'b0;
          cnt_n   = '0;
          state_n = WR;
        end
      end
      WR: begin
        cnt_n = cnt + AW'(1);
        if (cnt == LAST) begin
          cnt_n   = '0;
          state_n = RD;
        end
      end
      RD: begin
        cnt_n = cnt + AW'(1);
        if (cnt == LAST) begin
          cnt_n   = '0;
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (!ph) begin
          ph_n    = 1'b1;
          cnt_n   = '0;
          state_n = WR;
        end else begin
          state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so they line up with the state they describe.
  always_comb begin
    wr_n   = (state_n == WR);
    rd_n   = (state_n == RD);
    addr_n = (wr_n || rd_n) ? cnt_n : '0;
    data_n = wr_n ? DW'(pat(ph_n, 32'(cnt_n))) : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ph       <= 1'b0;
      cnt      <= '0;
      mem_rd   <= 1'b0;
      mem_wr   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
    end else begin
      state    <= state_n;
      ph       <= ph_n;
      cnt      <= cnt_n;
      mem_rd   <= rd_n;
      mem_wr   <= wr_n;
      mem_addr <= addr_n;
      mem_data <= data_n;
      busy     <= (state_n == WR) || (state_n == RD) || (state_n == DRAIN);
      done     <= (state_n == DONE);
      if (clr) begin
        pass <= 1'b0;
      end else if (state_n == DONE) begin
        pass <= clean;
      end
    end
  end

  assign rd_exp = DW'(pat(ph, 32'(mem_addr)));

  ram_bist_chk #(
    .AW(AW),
    .DW(DW)
  ) u_chk (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr),
    .rd       (mem_rd),
    .addr     (mem_addr),
    .rd_exp   (rd_exp),
    .dout     (mem_dout),
    .fail_addr(fail_addr),
    .fail_data(fail_data),
    .err_count(err_count),
    .clean    (clean)
  );

endmodule

// File: tb/tb_ram_32x8_bist.sv
// Self-checking bench for ram_32x8_bist: synchronous RAM model with selectable
// read faults, a cycle-indexed behavioural reference and directed/random scenarios.
module tb_ram_32x8_bist;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       mem_rd, mem_wr;
  logic [4:0] mem_addr;
  logic [7:0] mem_data;
  logic [7:0] mem_dout = '0;
  logic       busy, done, pass;
  logic [4:0] fail_addr;
  logic [7:0] fail_data;
  logic [6:0] err_count;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int          cyc = 0;
  int          fmode = 0;

  always #5 clk = ~clk;

  ram_32x8_bist #(
    .DEPTH(32),
    .AW   (5),
    .DW   (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_dout (mem_dout),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .fail_addr(fail_addr),
    .fail_data(fail_data),
    .err_count(err_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected word for address a in pass ph.
  function automatic logic [7:0] patm(input int ph, input int a);
    return (ph != 0) ? 8'(255 - a) : 8'(a);
  endfunction

  // Read faults: 1 = bit 3 stuck at 0 at address 5; 2 = words with msb clear read back as all ones.
  function automatic logic [7:0] flt(input logic [7:0] v, input int a, input int mode);
    if (mode == 1 && a == 5) return v & 8'hF7;
    if (mode == 2 && v < 8'd128) return 8'hFF;
    return v;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model
  logic [7:0] ram [32];
  logic [7:0] wr5 [$];
  int         wr_total = 0;

  always @(posedge clk) begin
    if (mem_wr) begin
      ram[mem_addr] <= mem_data;
      wr_total <= wr_total + 1;
      if (mem_addr == 5'd5) wr5.push_back(mem_data);
    end
    if (mem_rd) mem_dout <= flt(ram[mem_addr], int'(mem_addr), fmode);
  end

  // Reference model: k = cycles since the accepted start (0 = idle/sampling).
  int   k = 0;
  int   m_err = 0;
  bit   m_first = 0;
  int   m_faddr = 0;
  int   m_fdata = 0;
  bit   m_pass = 0;
  int   done_cnt = 0;
  int   last_done = -1000;

  always @(negedge clk) begin
    logic       e_wr, e_rd, e_busy, e_done;
    logic [4:0] e_addr;
    logic [7:0] e_data, rb;
    int         a, ph;
    if (!reset) begin
      chk("reset_outputs",
          {31'd0, mem_rd, mem_wr, busy, done, pass} | {7'd0, mem_addr, mem_data, fail_addr, fail_data, err_count},
          32'd0);
      k = 0; m_err = 0; m_first = 0; m_faddr = 0; m_fdata = 0; m_pass = 0;
    end else begin
      e_wr = 0; e_rd = 0; e_addr = '0; e_data = '0;
      e_busy = (k >= 1 && k <= 130);
      e_done = (k == 131);
      if (k >= 1 && k <= 32)        begin e_wr = 1; e_addr = 5'(k - 1);  e_data = patm(0, k - 1);  end
      else if (k >= 66 && k <= 97)  begin e_wr = 1; e_addr = 5'(k - 66); e_data = patm(1, k - 66); end
      else if (k >= 33 && k <= 64)  begin e_rd = 1; e_addr = 5'(k - 33); end
      else if (k >= 98 && k <= 129) begin e_rd = 1; e_addr = 5'(k - 98); end
      if (e_rd) begin
        a  = int'(e_addr);
        ph = (k >= 98) ? 1 : 0;
        rb = flt(patm(ph, a), a, fmode);
        if (rb != patm(ph, a)) begin
          m_err++;
          if (!m_first) begin m_first = 1; m_faddr = a; m_fdata = int'(rb); end
        end
      end
      if (k == 131) m_pass = (m_err == 0);
      chk("strobes", {30'd0, mem_rd, mem_wr}, {30'd0, e_rd, e_wr});
      chk("rd_wr_exclusive", {31'd0, mem_rd & mem_wr}, 32'd0);
      chk("mem_addr", {27'd0, mem_addr}, {27'd0, e_addr});
      chk("mem_data", {24'd0, mem_data}, {24'd0, e_data});
      chk("busy_done", {30'd0, busy, done}, {30'd0, e_busy, e_done});
      chk("pass", {31'd0, pass}, {31'd0, m_pass});
      if (k == 0 || k == 1 || k == 131)
        chk("stats", {12'd0, err_count, fail_addr, fail_data},
            {12'd0, 7'(m_err), 5'(m_faddr), 8'(m_fdata)});
      if (done) begin done_cnt++; last_done = cyc; end
      if (k == 0) begin
        if (start) begin
          k = 1; m_err = 0; m_first = 0; m_faddr = 0; m_fdata = 0; m_pass = 0;
        end
      end else if (k == 131) k = 0;
      else k++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start(output int s0);
    start = 1'b1;
    s0 = cyc;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int s0, input string nm);
    int t0;
    t0 = done_cnt;
    for (int i = 0; i < 400 && done_cnt == t0; i++) @(negedge clk);
    @(negedge clk);
    chk(nm, 32'(last_done - s0), 32'd131);
  endtask

  initial begin
    int s0, s1, n5, w0, d0, prev, pulses;
    reset = 1'b0;
    step(3);
    reset = 1'b1;
    step(2);

    // Fault-free run
    fmode = 0; n5 = wr5.size(); w0 = wr_total;
    pulse_start(s0);
    wait_done(s0, "A_done_cycle");
    chk("A_pass", {31'd0, pass}, 32'd1);
    chk("A_err_count", {25'd0, err_count}, 32'd0);
    chk("A_write_count", 32'(wr_total - w0), 32'd64);
    chk("A_addr5_writes", 32'(wr5.size() - n5), 32'd2);
    if (wr5.size() >= n5 + 2) begin
      chk("A_addr5_pass0", {24'd0, wr5[n5]}, 32'h05);
      chk("A_addr5_pass1", {24'd0, wr5[n5+1]}, 32'hFA);
    end
    step(2);

    // Stuck-at-0 on bit 3 at address 5
    fmode = 1;
    pulse_start(s0);
    wait_done(s0, "B_done_cycle");
    chk("B_pass", {31'd0, pass}, 32'd0);
    chk("B_err_count", {25'd0, err_count}, 32'd1);
    chk("B_fail_addr", {27'd0, fail_addr}, 32'd5);
    chk("B_fail_data", {24'd0, fail_data}, 32'hF2);
    step(2);

    // All-ones readback of pass-0 words
    fmode = 2;
    pulse_start(s0);
    wait_done(s0, "C_done_cycle");
    chk("C_pass", {31'd0, pass}, 32'd0);
    chk("C_err_count", {25'd0, err_count}, 32'd32);
    chk("C_fail_addr", {27'd0, fail_addr}, 32'd0);
    chk("C_fail_data", {24'd0, fail_data}, 32'hFF);
    fmode = 0;
    step(2);

    // Second start mid-run is ignored
    d0 = done_cnt;
    pulse_start(s0);
    step(49);
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_done(s0, "D_done_cycle");
    step(140);
    chk("D_done_pulses", 32'(done_cnt - d0), 32'd1);

    // Reset mid-run, then a full run
    pulse_start(s0);
    step(39);
    reset = 1'b0;
    step(5);
    reset = 1'b1;
    chk("E_pass_after_reset", {31'd0, pass}, 32'd0);
    step(1);
    pulse_start(s1);
    wait_done(s1, "E_done_cycle");
    chk("E_pass", {31'd0, pass}, 32'd1);
    step(2);

    // start held high: back-to-back runs
    start = 1'b1;
    s0 = cyc;
    prev = -1; pulses = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) begin
        if (prev < 0) chk("F_first_done", 32'(cyc - s0), 32'd131);
        else chk("F_done_gap", 32'(cyc - prev), 32'd132);
        prev = cyc;
        pulses++;
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
    chk("F_done_pulses", 32'(pulses), 32'd2);
    step(200);

    // Randomized runs: fault mode, spurious starts, occasional mid-run reset
    for (int r = 0; r < 8; r++) begin
      fmode = int'($urandom_range(0, 2));
      step(int'($urandom_range(1, 5)));
      pulse_start(s0);
      if ($urandom_range(0, 3) == 0) begin
        step(int'($urandom_range(1, 120)));
        reset = 1'b0;
        step(int'($urandom_range(1, 4)));
        reset = 1'b1;
        step(2);
      end else begin
        step(int'($urandom_range(1, 100)));
        start = 1'b1;
        step(1);
        start = 1'b0;
        wait_done(s0, "R_done_cycle");
        step(2);
      end
    end
    step(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_32x8_bist.md
# ram_32x8_bist

Built-in self-test initiator for the 32x8 single-port RAM. It drives the RAM's rd/wr/addr/data port as the bus master and checks the returned dout against an expected pattern. On a `start` pulse it runs two full passes: an address pattern, then its inverse. It reports pass/fail, the first failing location and the total error count. It sits beside the RAM and is muxed onto the RAM port in test mode.

## Interface
- `DEPTH`, default 32: number of RAM words.
- `AW`, default 5: address width; `DEPTH` == 2**`AW`.
- `DW`, default 8: data width; must be ≥ `AW`.
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: one clock; reset is asynchronous and active-low.
- `start`  in  1: begin a test run; sampled only in IDLE.
- `mem_rd`  out  1: RAM read strobe.
- `mem_wr`  out  1: RAM write strobe.
- `mem_addr`  out  AW: RAM address.
- `mem_data`  out  DW: RAM write data.
- `mem_dout`  in  DW: RAM read data, valid the cycle after `mem_rd` was high.
- `busy`  out  1: high from the cycle after `start` is accepted until `done`.
- `done`  out  1: one-cycle pulse at the end of a run.
- `pass`  out  1: 1 if the last run had zero mismatches; held until the next `start`.
- `fail_addr`  out  AW: address of the first mismatch of the run.
- `fail_data`  out  DW: data read at the first mismatch.
- `err_count`  out  AW+2: number of mismatching reads in the run (max 2*DEPTH, no saturation needed).

## Operation
- States: IDLE, WR, RD, DRAIN, DONE. A phase bit `ph` selects the pass (0 or 1).
- Patterns:
  - P0(a) = `a` zero-extended to DW.
  - P1(a) = ~P0(a), all DW bits inverted.
- IDLE:
  - If `start` is high, clear `pass`, `fail_addr`, `fail_data`, `err_count` and the first-fail flag.
  - Set `ph`=0, addr counter=0, and go to WR.
- WR: `mem_wr`=1, `mem_addr`=counter, `mem_data`=P`ph`(counter). Increment the counter. After address DEPTH-1, wrap the counter to 0 and go to RD.
- RD:
  - `mem_rd`=1, `mem_addr`=counter. Increment the counter.
  - Each cycle, compare `mem_dout` with the expected value of the address issued in the previous RD cycle, through a one-entry expected/address pipeline.
  - After address DEPTH-1, go to DRAIN.
- DRAIN: no strobes. Compare the final read.
  - If `ph`=0: set `ph`=1, counter=0, go to WR.
  - If `ph`=1: go to DONE.
- DONE: `done`=1; `pass`=(`err_count`==0). Return to IDLE.
- On a mismatch: increment `err_count`. If it is the first mismatch of the run, capture `fail_addr`/`fail_data`.
- `mem_rd` and `mem_wr` are never high in the same cycle. In non-strobe cycles `mem_addr` and `mem_data` are 0.
- `start` outside IDLE is ignored. Holding `start` high starts a new run in the cycle after DONE returns to IDLE.

## Timing
- All outputs are registered.
- Reset values: every output 0, state IDLE, `ph`=0, counters 0.
- Reset asserted mid-run:
  - Strobes drop immediately and the run is aborted.
  - No `done` pulse is produced; `pass` stays 0.
  - RAM contents are left undefined.
- Cycle numbering: the cycle in which `start` is sampled in IDLE is cycle 0. With DEPTH=32:
  - Cycles 1–32: WR pass 0, addresses 0–31.
  - Cycles 33–64: RD pass 0.
  - Cycle 65: DRAIN.
  - Cycles 66–97: WR pass 1.
  - Cycles 98–129: RD pass 1.
  - Cycle 130: DRAIN.
  - Cycle 131: `done`=1.
- General latency: `done` in cycle 4*DEPTH+3.
- `busy`: high in cycles 1 through 4*DEPTH+2, low in the `done` cycle.
- Read compare: the read issued in cycle n is checked against `mem_dout` in cycle n+1.

## Structure
- Shared package `ram_pkg`:
  - DEPTH/AW/DW constants.
  - State enum (IDLE, WR, RD, DRAIN, DONE).
  - Pattern function P(ph, a).
- One natural sub-module, `ram_bist_chk`. It holds the expected/address pipeline register, the comparator, first-fail capture and `err_count`.
- The top module holds the FSM, counters and strobe generation.

## Test plan
- Fault-free RAM model, `start` pulse at cycle 0:
  - `done` in cycle 131, `pass`=1, `err_count`=0.
  - 64 writes observed: addr 5 gets 0x05 in pass 0 and 0xFA in pass 1.
- RAM model with `dout[3]` stuck-at-0 at address 5:
  - `pass`=0, `err_count`=1, `fail_addr`=5, `fail_data`=0xF2.
- RAM model with all-ones readback: `err_count`=32 (pass 0 only), `fail_addr`=0, `fail_data`=0xFF.
- Second `start` pulse at cycle 50 during a run: ignored; `done` is still in cycle 131 and there is exactly one pulse.
- Reset asserted at cycle 40, released at 45, then `start`:
  - During reset: all outputs 0.
  - After the new `start`: a full run completes with `pass`=1 and `done` 131 cycles after that `start`.
- `start` held high for 300 cycles:
  - Runs are back to back, with `done` pulses 132 cycles apart.
  - No cycle has `mem_rd` and `mem_wr` high together.
